// File: rtl/alu_sequencer_if.sv
// Bundle of request, ALU-drive and response signals shared by the sequencer and its environment.
// The slave modport is the sequencer; the master modport is the requesters, ALU and consumer.
interface alu_sequencer_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0;
    logic [15:0] req_b0;
    logic [15:0] req_a1;
    logic [15:0] req_b1;
    logic [2:0]  req_op0;
    logic [2:0]  req_op1;
    logic        req_mode0;
    logic        req_mode1;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_mode;
    logic [31:0] alu_out;
    logic        alu_za;
    logic        alu_zb;
    logic        alu_eq;
    logic        alu_gt;
    logic        alu_lt;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
               req_mode0, req_mode1, alu_out, alu_za, alu_zb, alu_eq, alu_gt,
               alu_lt, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, alu_mode, rsp_valid,
               rsp_id, rsp_data, rsp_flags, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
               req_mode0, req_mode1, alu_out, alu_za, alu_zb, alu_eq, alu_gt,
               alu_lt, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode, alu_mode, rsp_valid,
               rsp_id, rsp_data, rsp_flags, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin sequencer sharing one 16-bit ALU between two requesters: accept, settle, capture,
// then hold the response until the consumer takes it.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last_id;
    logic [1:0]  grant;
    logic        gid;

    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic        alu_mode_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_flags_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_id ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign gid = grant[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_id     <= 1'b1;
            alu_a_q     <= 16'd0;
            alu_b_q     <= 16'd0;
            alu_op_q    <= 3'd0;
            alu_mode_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_flags_q <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        alu_a_q    <= gid ? bus.req_a1    : bus.req_a0;
                        alu_b_q    <= gid ? bus.req_b1    : bus.req_b0;
                        alu_op_q   <= gid ? bus.req_op1   : bus.req_op0;
                        alu_mode_q <= gid ? bus.req_mode1 : bus.req_mode0;
                        rsp_id_q   <= gid;
                        last_id    <= gid;
                        cnt        <= CNT_INIT;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data_q  <= bus.alu_out;
                        rsp_flags_q <= {bus.alu_za, bus.alu_zb, bus.alu_eq,
                                        bus.alu_gt, bus.alu_lt};
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_mode   = alu_mode_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a transaction-level model checked every cycle on the default-settle
// instance, directed literal checks on both instances, and a reference ALU feeding each DUT.
module tb_alu_sequencer;

    localparam int SETTLE0 = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic started = 1'b0;

    alu_sequencer_if if0 ();
    alu_sequencer_if if1 ();

    alu_sequencer #(.SETTLE_CYCLES(SETTLE0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    alu_sequencer #(.SETTLE_CYCLES(1))       dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op, input logic mode);
        if (!mode) begin
            case (op)
                3'd0:    return {16'd0, a} + {16'd0, b};
                3'd1:    return {16'd0, a} - {16'd0, b};
                3'd2:    return {16'd0, a} * {16'd0, b};
                default: return {a, b};
            endcase
        end else begin
            case (op)
                3'd0:    return {16'd0, a & b};
                3'd1:    return {16'd0, a | b};
                3'd2:    return {16'd0, a ^ b};
                default: return {16'd0, ~a};
            endcase
        end
    endfunction

    function automatic logic [4:0] flags_of(input logic [15:0] a, input logic [15:0] b);
        return {a == 16'd0, b == 16'd0, a == b, a > b, a < b};
    endfunction

    function automatic logic [1:0] pick(input logic [1:0] valid, input logic last);
        if (valid == 2'b11) return last ? 2'b01 : 2'b10;
        return valid;
    endfunction

    assign if0.alu_out = ref_alu(if0.alu_a, if0.alu_b, if0.alu_opcode, if0.alu_mode);
    assign {if0.alu_za, if0.alu_zb, if0.alu_eq, if0.alu_gt, if0.alu_lt} = flags_of(if0.alu_a, if0.alu_b);
    assign if1.alu_out = ref_alu(if1.alu_a, if1.alu_b, if1.alu_opcode, if1.alu_mode);
    assign {if1.alu_za, if1.alu_zb, if1.alu_eq, if1.alu_gt, if1.alu_lt} = flags_of(if1.alu_a, if1.alu_b);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s got no event within bound, expected one, at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [2:0] op0, input logic mode0,
                                 input logic [15:0] a1, input logic [15:0] b1,
                                 input logic [2:0] op1, input logic mode1);
        if0.req_valid = valid;
        if0.req_a0 = a0;  if0.req_b0 = b0;  if0.req_op0 = op0;  if0.req_mode0 = mode0;
        if0.req_a1 = a1;  if0.req_b1 = b1;  if0.req_op1 = op1;  if0.req_mode1 = mode1;
    endtask

    task automatic waitGrant(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 40 && g == 2'b00; i++) begin
            @(negedge clk);
            g = if0.req_ready;
        end
        if (g == 2'b00) timeoutFail("grant_wait");
    endtask

    task automatic waitRsp();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = if0.rsp_valid;
        end
        if (!seen) timeoutFail("rsp_wait");
    endtask

    task automatic waitIdle();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = !if0.busy;
        end
        if (!seen) timeoutFail("idle_wait");
    endtask

    // Transaction model: one operation in flight, its age since accept, and the pending response.
    logic        m_inflight = 1'b0;
    logic        m_rv = 1'b0;
    int          m_age = 0;
    logic        m_last = 1'b1;
    logic [15:0] m_a = 16'd0;
    logic [15:0] m_b = 16'd0;
    logic [2:0]  m_op = 3'd0;
    logic        m_mode = 1'b0;
    logic        m_rid = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic [4:0]  m_rflags = 5'd0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            m_inflight <= 1'b0;  m_rv <= 1'b0;  m_age <= 0;  m_last <= 1'b1;
            m_a <= 16'd0;  m_b <= 16'd0;  m_op <= 3'd0;  m_mode <= 1'b0;
            m_rid <= 1'b0;  m_rdata <= 32'd0;  m_rflags <= 5'd0;
        end else if (m_rv) begin
            if (if0.rsp_ready) m_rv <= 1'b0;
        end else if (m_inflight) begin
            if (m_age + 1 == SETTLE0) begin
                m_inflight <= 1'b0;
                m_rv       <= 1'b1;
                m_rdata    <= ref_alu(m_a, m_b, m_op, m_mode);
                m_rflags   <= flags_of(m_a, m_b);
            end else begin
                m_age <= m_age + 1;
            end
        end else if (pick(if0.req_valid, m_last) != 2'b00) begin
            if (pick(if0.req_valid, m_last) == 2'b10) begin
                m_a <= if0.req_a1;  m_b <= if0.req_b1;  m_op <= if0.req_op1;  m_mode <= if0.req_mode1;
                m_rid <= 1'b1;  m_last <= 1'b1;
            end else begin
                m_a <= if0.req_a0;  m_b <= if0.req_b0;  m_op <= if0.req_op0;  m_mode <= if0.req_mode0;
                m_rid <= 1'b0;  m_last <= 1'b0;
            end
            m_inflight <= 1'b1;
            m_age      <= 0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_ready;
        if (started) begin
            exp_ready = (rst_n && !m_inflight && !m_rv) ? pick(if0.req_valid, m_last) : 2'b00;
            checkOutput("req_ready",  32'(if0.req_ready),  32'(exp_ready));
            checkOutput("busy",       32'(if0.busy),       32'(m_inflight | m_rv));
            checkOutput("alu_a",      32'(if0.alu_a),      32'(m_a));
            checkOutput("alu_b",      32'(if0.alu_b),      32'(m_b));
            checkOutput("alu_opcode", 32'(if0.alu_opcode), 32'(m_op));
            checkOutput("alu_mode",   32'(if0.alu_mode),   32'(m_mode));
            checkOutput("rsp_valid",  32'(if0.rsp_valid),  32'(m_rv));
            checkOutput("rsp_id",     32'(if0.rsp_id),     32'(m_rid));
            checkOutput("rsp_data",   if0.rsp_data,        m_rdata);
            checkOutput("rsp_flags",  32'(if0.rsp_flags),  32'(m_rflags));
        end
    end

    initial begin
        logic [1:0] g;

        checkOutput("model_flags_lt",  32'(flags_of(16'h0003, 16'h000F)), 32'h01);
        checkOutput("model_flags_eq",  32'(flags_of(16'h00E9, 16'h00E9)), 32'h04);
        checkOutput("model_flags_zero", 32'(flags_of(16'h0000, 16'h0000)), 32'h1C);
        checkOutput("model_mul", ref_alu(16'h1234, 16'h0042, 3'd2, 1'b0), 32'h0004B168);

        rst_n = 1'b0;
        if0.rsp_ready = 1'b1;
        applyStimulus(2'b11, 16'h00E9, 16'h00E9, 3'd0, 1'b0, 16'h00E9, 16'h00E9, 3'd0, 1'b0);
        if1.rsp_ready = 1'b1;
        if1.req_valid = 2'b00;
        if1.req_a0 = 16'd0;  if1.req_b0 = 16'd0;  if1.req_op0 = 3'd0;  if1.req_mode0 = 1'b1;
        if1.req_a1 = 16'd0;  if1.req_b1 = 16'd0;  if1.req_op1 = 3'd0;  if1.req_mode1 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(if0.req_ready), 32'h0);
        checkOutput("rst_busy",      32'(if0.busy),      32'h0);
        checkOutput("rst_rsp_valid", 32'(if0.rsp_valid), 32'h0);
        checkOutput("rst_rsp_data",  if0.rsp_data,       32'h0);
        checkOutput("rst_alu_a",     32'(if0.alu_a),     32'h0);
        checkOutput("rst1_rsp_valid", 32'(if1.rsp_valid), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("[TB] round-robin tie");
        for (int k = 0; k < 4; k++) begin
            waitGrant(g);
            checkOutput("tie_grant", 32'(g), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk); #1;
            if (k == 3) if0.req_valid = 2'b00;
            waitRsp();
            checkOutput("tie_flags", 32'(if0.rsp_flags), 32'h04);
            checkOutput("tie_id",    32'(if0.rsp_id),    32'(k % 2));
        end

        $display("[TB] single request from requester 1");
        waitIdle();
        @(posedge clk); #1;
        applyStimulus(2'b10, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0003, 16'h000F, 3'b001, 1'b1);
        @(negedge clk);
        checkOutput("single_grant", 32'(if0.req_ready), 32'h2);
        @(posedge clk); #1 if0.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("single_valid_e0", 32'(if0.rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("single_valid_e1", 32'(if0.rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("single_valid_e2", 32'(if0.rsp_valid), 32'h1);
        checkOutput("single_id",    32'(if0.rsp_id),    32'h1);
        checkOutput("single_flags", 32'(if0.rsp_flags), 32'h01);
        checkOutput("single_data",  if0.rsp_data,       32'h0000000F);

        $display("[TB] backpressure");
        waitIdle();
        @(posedge clk); #1;
        if0.rsp_ready = 1'b0;
        applyStimulus(2'b01, 16'h1234, 16'h0042, 3'd2, 1'b0, 16'h0005, 16'h0005, 3'd0, 1'b0);
        waitGrant(g);
        checkOutput("bp_grant", 32'(g), 32'h1);
        @(posedge clk); #1 if0.req_valid = 2'b10;
        waitRsp();
        checkOutput("bp_data",  if0.rsp_data,       32'h0004B168);
        checkOutput("bp_flags", 32'(if0.rsp_flags), 32'h02);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_ready", 32'(if0.req_ready), 32'h0);
            checkOutput("bp_hold_data",  if0.rsp_data,       32'h0004B168);
            checkOutput("bp_hold_id",    32'(if0.rsp_id),    32'h0);
        end
        @(posedge clk); #1 if0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_pending_grant", 32'(if0.req_ready), 32'h2);
        @(posedge clk); #1 if0.req_valid = 2'b00;
        waitRsp();
        checkOutput("bp2_data",  if0.rsp_data,       32'h0000000A);
        checkOutput("bp2_flags", 32'(if0.rsp_flags), 32'h04);
        checkOutput("bp2_id",    32'(if0.rsp_id),    32'h1);

        $display("[TB] reset during settle");
        waitIdle();
        @(posedge clk); #1;
        applyStimulus(2'b01, 16'h0007, 16'h0009, 3'd0, 1'b0, 16'h00E9, 16'h00E9, 3'd0, 1'b0);
        @(negedge clk);
        checkOutput("mid_grant", 32'(if0.req_ready), 32'h1);
        @(posedge clk); #1 if0.req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("mid_no_rsp", 32'(if0.rsp_valid), 32'h0);
        end
        @(posedge clk); #1 if0.req_valid = 2'b11;
        waitGrant(g);
        checkOutput("mid_tie_grant", 32'(g), 32'h1);
        @(posedge clk); #1 if0.req_valid = 2'b00;
        waitRsp();
        checkOutput("mid_rsp_id", 32'(if0.rsp_id), 32'h0);

        $display("[TB] zero flags with one settle cycle");
        @(posedge clk); #1 if1.req_valid = 2'b01;
        @(negedge clk);
        checkOutput("z_grant", 32'(if1.req_ready), 32'h1);
        @(posedge clk); #1 if1.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("z_valid_e0", 32'(if1.rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("z_valid_e1", 32'(if1.rsp_valid), 32'h1);
        checkOutput("z_flags",    32'(if1.rsp_flags), 32'h1C);
        checkOutput("z_data",     if1.rsp_data,       32'h0);
        checkOutput("z_id",       32'(if1.rsp_id),    32'h0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
